dance_sequencer: RTL
====================

Name: dance_sequencer

Overview:
Controller that sequences the 18-LED dance datapath. It resolves the switch requests into a single active pattern mode, or runs an automatic playlist. It generates the slow step strobe from a prescaler and issues a one-cycle clear whenever the active mode changes. The datapath advances its LED position only on step and reinitialises on clear.

Parameters:
TICK_DIV, 16777216, Clock cycles per step (>=2).
NUM_LEDS, 18, LED count in the chain.
LAPS_PER_MODE, 2, completed laps per mode before the auto playlist advances.

Ports:
Clock  in  1  system clock, all state on rising edge
Reset  in  1  synchronous, active-high
SW  in  4  [0] shift-up request, [1] shift-down request, [2] bounce request, [3] auto playlist enable
mode  out  2  active mode: 0 NONE, 1 SHIFT_UP, 2 SHIFT_DOWN, 3 BOUNCE
step  out  1  one-cycle strobe, datapath advances one position
clear  out  1  one-cycle strobe, datapath zeroes LEDs and position
busy  out  1  high while mode != NONE
lap_count  out  clog2(LAPS_PER_MODE+1)  completed laps in current mode
step_count  out  clog2(2*NUM_LEDS)  steps within current lap

Behaviour:
- Reset (synchronous, active-high): on the next edge mode=0, step=0, clear=0, busy=0, lap_count=0, step_count=0, prescaler=0, auto_mode=SHIFT_UP, state=IDLE. Reset wins over every other event.
- Requested mode, combinational:
  - SW[3]=1: req = auto_mode.
  - SW[3]=0: fixed priority SW[0] > SW[1] > SW[2]; none set -> NONE.
- FSM states: IDLE, CLEAR, RUN.
  - IDLE or RUN with req != mode: mode <= req, state <= CLEAR.
  - IDLE with req == NONE: stay in IDLE.
  - CLEAR: clear=1 for exactly this one cycle; prescaler, step_count and lap_count are zeroed. Next state is RUN if mode != NONE, else IDLE.
  - RUN: prescaler counts 0..TICK_DIV-1 and wraps.
- step = (state==RUN) && (prescaler==TICK_DIV-1), decoded from registers. The first step comes in the TICK_DIV-th RUN cycle after clear.
- A mode change detected in a cycle where the prescaler is at terminal count takes priority: step=0 that cycle, CLEAR follows.
- Lap length L: NUM_LEDS for SHIFT_UP/SHIFT_DOWN (18); 2*(NUM_LEDS-1) for BOUNCE (34).
- On each step: step_count++. At step_count==L-1 it wraps to 0 and lap_count++, saturating at LAPS_PER_MODE.
- Auto playlist (SW[3]=1): on the step that makes lap_count reach LAPS_PER_MODE, auto_mode advances SHIFT_UP -> SHIFT_DOWN -> BOUNCE -> SHIFT_UP. req then differs, so CLEAR follows on the next cycle.
- In manual mode lap_count saturates and has no effect.
- Toggling SW[3] 0->1: auto_mode keeps its last value (SHIFT_UP after reset). A resulting mode change goes through CLEAR like any other change.
- Switches are sampled without debounce. Any req change, including to NONE, yields exactly one clear pulse.
- All outputs except step are registered.

Decomposition:
- Shared package dance_pkg: mode encoding constants (MODE_NONE, MODE_SHIFT_UP, MODE_SHIFT_DOWN, MODE_BOUNCE), FSM state encoding, NUM_LEDS default.
- One natural sub-module: dance_tick_gen. It holds the prescaler with a sync zero input and a terminal-count output, and is reusable by other slow-display blocks.

Test Plan:
Bench settings: TICK_DIV=4, NUM_LEDS=18, LAPS_PER_MODE=2.
1. Reset=1 for 2 cycles, SW=0000 -> mode=0, step=0, clear=0, busy=0, counters 0. Holding Reset=1 with SW=0001 keeps all outputs 0.
2. SW=0001 after reset -> clear high exactly 1 cycle; mode=1, busy=1; step pulses 1 cycle in every 4, first step 4 cycles after the clear cycle. step_count wraps 17->0 and lap_count increments to 1.
3. SW=0111 -> mode=1 (priority). Switch to 0110 -> one clear pulse, mode=2, step_count=0, lap_count=0. SW=0000 -> one clear, mode=0, busy=0, no further steps.
4. SW=1000 from reset -> mode=1 for 36 steps, clear, mode=2 for 36 steps, clear, mode=3 for 68 steps, clear, mode=1. Exactly one clear at each transition.
5. Change SW from 0001 to 0010 in a cycle where prescaler==3 -> step=0 that cycle, clear next cycle, first step of mode 2 four cycles later.
6. Assert Reset for 1 cycle mid-RUN in auto mode at mode=3 -> next cycle all outputs 0. Release with SW=1000 -> clear pulse, mode=1 (auto_mode restored to SHIFT_UP).

Source files
------------

// File: rtl/dance_pkg.sv
// Shared encodings and helpers for the LED dance controller and its datapath.
package dance_pkg;

  localparam logic [1:0] MODE_NONE       = 2'd0;
  localparam logic [1:0] MODE_SHIFT_UP   = 2'd1;
  localparam logic [1:0] MODE_SHIFT_DOWN = 2'd2;
  localparam logic [1:0] MODE_BOUNCE     = 2'd3;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StClear = 2'd1;
  localparam logic [1:0] StRun   = 2'd2;

  localparam int unsigned DefaultNumLeds = 18;

  // Bounce visits both ends once per lap, so it never repeats an end LED.
  function automatic int unsigned lap_len(input logic [1:0] mode, input int unsigned num_leds);
    return (mode == MODE_BOUNCE) ? 2 * (num_leds - 1) : num_leds;
  endfunction

  function automatic logic [1:0] next_auto_mode(input logic [1:0] mode);
    logic [1:0] nxt;
    case (mode)
      MODE_SHIFT_UP:   nxt = MODE_SHIFT_DOWN;
      MODE_SHIFT_DOWN: nxt = MODE_BOUNCE;
      default:         nxt = MODE_SHIFT_UP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/dance_tick_gen.sv
// Free-running prescaler with synchronous zero and a terminal-count flag,
// usable by any slow-display block that needs a divided step strobe.
module dance_tick_gen #(
  parameter int unsigned TickDiv = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic zero_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CntW = (TickDiv > 1) ? $clog2(TickDiv) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TickDiv - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (zero_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CntMax);

endmodule

// File: rtl/dance_sequencer.sv
// Mode arbitration, auto playlist and step/clear strobes for the 18-LED dance datapath.
module dance_sequencer
  import dance_pkg::*;
#(
  parameter int unsigned TICK_DIV      = 16777216,
  parameter int unsigned NUM_LEDS      = DefaultNumLeds,
  parameter int unsigned LAPS_PER_MODE = 2
) (
  input  logic                                   Clock,
  input  logic                                   Reset,
  input  logic [3:0]                             SW,
  output logic [1:0]                             mode,
  output logic                                   step,
  output logic                                   clear,
  output logic                                   busy,
  output logic [$clog2(LAPS_PER_MODE + 1)-1:0]   lap_count,
  output logic [$clog2(2 * NUM_LEDS)-1:0]        step_count
);

  localparam int unsigned LapW  = $clog2(LAPS_PER_MODE + 1);
  localparam int unsigned StepW = $clog2(2 * NUM_LEDS);
  localparam logic [LapW-1:0] LapMax = LapW'(LAPS_PER_MODE);

  logic [1:0]       state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [1:0]       auto_mode_q, auto_mode_d;
  logic [LapW-1:0]  lap_count_q, lap_count_d;
  logic [StepW-1:0] step_count_q, step_count_d;
  logic             clear_q, busy_q;

  logic [1:0]       req;
  logic             mode_change;
  logic             tick_tc;
  logic             tick_zero;
  logic             tick_en;
  logic [StepW-1:0] lap_last;

  always_comb begin
    req = MODE_NONE;
    if (SW[3]) begin
      req = auto_mode_q;
    end else if (SW[0]) begin
      req = MODE_SHIFT_UP;
    end else if (SW[1]) begin
      req = MODE_SHIFT_DOWN;
    end else if (SW[2]) begin
      req = MODE_BOUNCE;
    end
  end

  assign mode_change = (req != mode_q);
  assign tick_zero   = (state_q == StClear);
  assign tick_en     = (state_q == StRun);
  assign lap_last    = StepW'(lap_len(mode_q, NUM_LEDS) - 1);

  dance_tick_gen #(
    .TickDiv (TICK_DIV)
  ) u_tick_gen (
    .clk_i  (Clock),
    .rst_i  (Reset),
    .zero_i (tick_zero),
    .en_i   (tick_en),
    .tc_o   (tick_tc)
  );

  // A pending mode change suppresses the step so the old pattern never advances
  // in the same cycle that the new one is latched.
  assign step = (state_q == StRun) && tick_tc && !mode_change;

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    auto_mode_d  = auto_mode_q;
    lap_count_d  = lap_count_q;
    step_count_d = step_count_q;

    case (state_q)
      StIdle: begin
        if (mode_change) begin
          mode_d  = req;
          state_d = StClear;
        end
      end
      StClear: begin
        lap_count_d  = '0;
        step_count_d = '0;
        state_d      = (mode_q != MODE_NONE) ? StRun : StIdle;
      end
      StRun: begin
        if (mode_change) begin
          mode_d  = req;
          state_d = StClear;
        end else if (step) begin
          if (step_count_q == lap_last) begin
            step_count_d = '0;
            if (lap_count_q != LapMax) begin
              lap_count_d = lap_count_q + LapW'(1);
            end
            if (SW[3] && (lap_count_q == LapMax - LapW'(1))) begin
              auto_mode_d = next_auto_mode(auto_mode_q);
            end
          end else begin
            step_count_d = step_count_q + StepW'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
        mode_d  = MODE_NONE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= StIdle;
      mode_q       <= MODE_NONE;
      auto_mode_q  <= MODE_SHIFT_UP;
      lap_count_q  <= '0;
      step_count_q <= '0;
      clear_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      auto_mode_q  <= auto_mode_d;
      lap_count_q  <= lap_count_d;
      step_count_q <= step_count_d;
      clear_q      <= (state_d == StClear);
      busy_q       <= (mode_d != MODE_NONE);
    end
  end

  assign mode       = mode_q;
  assign clear      = clear_q;
  assign busy       = busy_q;
  assign lap_count  = lap_count_q;
  assign step_count = step_count_q;

endmodule
